// File: rtl/majority_pkg.sv
// majority_pkg: FSM state type, tie rule and majority decision shared by majority_sched.
package majority_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    COLLECT = 2'd2,
    REPORT  = 2'd3
  } state_t;

  localparam bit TIE_ONE   = 1'b1;
  localparam int MAJ_CNT_W = 16;

  // Doubling is done one bit wider than the counters so it can never wrap.
  function automatic logic majority(input logic [MAJ_CNT_W-1:0] ones,
                                    input logic [MAJ_CNT_W-1:0] samples);
    logic [MAJ_CNT_W:0] twice;
    logic [MAJ_CNT_W:0] total;
    twice = {ones, 1'b0};
    total = {1'b0, samples};
    return TIE_ONE ? (twice >= total) : (twice > total);
  endfunction

endpackage

// File: rtl/maj_accum.sv
// maj_accum: window-length latch, sample/ones counters, last-sample detect and majority result.
module maj_accum
  import majority_pkg::*;
#(
  parameter int MAX_WIN = 255,
  parameter int CW      = $clog2(MAX_WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic [CW-1:0] win_len_i,
  input  logic          accept_i,
  input  logic          bit_i,
  output logic          last_o,
  output logic          result_o
);

  localparam logic [CW-1:0] MAX_WIN_C = CW'(MAX_WIN);

  logic [CW-1:0] wlen_q, wlen_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [CW-1:0] smp_q, smp_d;
  logic [CW-1:0] smp_inc;
  logic [CW-1:0] wlen_clip;

  // Saturation only exists when CW is wider than MAX_WIN needs.
  generate
    if (MAX_WIN < (2 ** CW) - 1) begin : g_sat
      assign wlen_clip = (win_len_i > MAX_WIN_C) ? MAX_WIN_C : win_len_i;
    end else begin : g_nosat
      assign wlen_clip = win_len_i;
    end
  endgenerate

  assign smp_inc = smp_q + CW'(1);

  always_comb begin
    wlen_d = wlen_q;
    ones_d = ones_q;
    smp_d  = smp_q;
    if (clear_i) begin
      wlen_d = (wlen_clip == '0) ? CW'(1) : wlen_clip;
      ones_d = '0;
      smp_d  = '0;
    end else if (accept_i) begin
      smp_d  = smp_inc;
      ones_d = ones_q + CW'(bit_i);
    end
  end

  assign last_o   = accept_i && (smp_inc == wlen_q);
  assign result_o = majority(MAJ_CNT_W'(ones_q), MAJ_CNT_W'(smp_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wlen_q <= '0;
      ones_q <= '0;
      smp_q  <= '0;
    end else begin
      wlen_q <= wlen_d;
      ones_q <= ones_d;
      smp_q  <= smp_d;
    end
  end

endmodule

// File: rtl/majority_sched.sv
// majority_sched: round-robin scheduler sharing one majority-vote engine among NREQ bit streams.
// Optional: define MAJ_TIMEOUT_EN to abandon a window after TIMEOUT cycles without a sample.
module majority_sched
  import majority_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_WIN = 255,
  parameter int CW      = $clog2(MAX_WIN + 1),
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] bit_in,
  input  logic [NREQ-1:0] bit_vld,
  input  logic [CW-1:0]   win_len,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            done,
  output logic            result,
  output logic [NREQ-1:0] done_id,
  output logic            abort
);

  localparam int IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_id_q, done_id_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            result_q, result_d;
  logic            abort_q, abort_d;

  logic [IW-1:0]   gidx_next;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [IW:0]     arb_sum;
  logic [IW-1:0]   arb_idx;
  logic            accept;
  logic            acc_last;
  logic            acc_result;
  logic            timeout_hit;

  assign accept    = (state_q == COLLECT) && bit_vld[gidx_q];
  assign gidx_next = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);

  // Walk from the farthest offset down so the nearest requester at/after rr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    arb_sum  = '0;
    arb_idx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      arb_sum = {1'b0, rr_q} + (IW + 1)'(i);
      arb_idx = (arb_sum >= (IW + 1)'(NREQ)) ? IW'(arb_sum - (IW + 1)'(NREQ)) : IW'(arb_sum);
      if (req[arb_idx]) begin
        pick_vld = 1'b1;
        pick_idx = arb_idx;
      end
    end
  end

  maj_accum #(
    .MAX_WIN (MAX_WIN),
    .CW      (CW)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == GRANT),
    .win_len_i (win_len),
    .accept_i  (accept),
    .bit_i     (bit_in[gidx_q]),
    .last_o    (acc_last),
    .result_o  (acc_result)
  );

`ifdef MAJ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if ((state_q != COLLECT) || accept) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + TW'(1);
    end
  end

  assign timeout_hit = (state_q == COLLECT) && !accept && (idle_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  // Watchdog compiled out: constant low for any legal TIMEOUT.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    result_d  = result_q;
    done_id_d = done_id_q;
    busy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = NREQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: state_d = COLLECT;
      COLLECT: begin
        // Completion takes priority over a req drop in the same cycle.
        if (acc_last) begin
          state_d = REPORT;
        end else if (!req[gidx_q] || timeout_hit) begin
          abort_d = 1'b1;
          gnt_d   = '0;
          rr_d    = gidx_next;
          state_d = IDLE;
        end
      end
      REPORT: begin
        done_d    = 1'b1;
        result_d  = acc_result;
        done_id_d = gnt_q;
        gnt_d     = '0;
        rr_d      = gidx_next;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == GRANT) || (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      rr_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 1'b0;
      done_id_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      rr_q      <= rr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
      abort_q   <= abort_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign done_id = done_id_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_majority_sched.sv
// tb_majority_sched: randomized windows checked against a transaction-level majority/round-robin model.
module tb_majority_sched;

  localparam int N  = 4;
  localparam int NW = $clog2(N);
  localparam int MW = 255;
  localparam int CW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  bit_in;
  logic [N-1:0]  bit_vld;
  logic [CW-1:0] win_len;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          done;
  logic          result;
  logic [N-1:0]  done_id;
  logic          abort;

  int n_assert = 0;
  int n_fail   = 0;
  int rr_m     = 0;

  majority_sched #(
    .NREQ    (N),
    .MAX_WIN (MW),
    .CW      (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .bit_in  (bit_in),
    .bit_vld (bit_vld),
    .win_len (win_len),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .done_id (done_id),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester at or after the pointer, cyclically.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (p + i) % N;
      if (r[NW'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_cross(input int g);
    for (int i = 0; i < N; i++) begin
      if (i != g) begin
        bit_vld[NW'(i)] = 1'($urandom);
        bit_in[NW'(i)]  = 1'($urandom);
      end
    end
  endtask

  task automatic wait_grant(output int g);
    int waited;
    waited = 0;
    g = pick(req, rr_m);
    while (gnt === '0 && waited < 20) begin
      drive_cross(-1);
      tick();
      waited++;
    end
    chk("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("busy_at_gnt", 32'(busy), 32'd1);
    chk("done_low_at_gnt", 32'(done), 32'd0);
    chk("abort_low_at_gnt", 32'(abort), 32'd0);
    if (g < 0) g = 0;
    // GRANT cycle: the granted line is idle, others chatter.
    bit_vld[NW'(g)] = 1'b0;
    bit_in[NW'(g)]  = 1'($urandom);
    drive_cross(g);
    tick();
  endtask

  task automatic run_window(input int wl, input int gap, input bit rnd, input logic [15:0] pat);
    int g, len, acc, ones, cyc;
    bit early, v, b;
    win_len = CW'(wl);
    wait_grant(g);
    len = (wl == 0) ? 1 : ((wl > MW) ? MW : wl);
    acc = 0; ones = 0; cyc = 0; early = 1'b0;
    while (acc < len && cyc < 4000) begin
      v = ($urandom_range(99) >= gap);
      if (v) begin
        b = rnd ? 1'($urandom) : pat[4'(acc)];
        acc++;
        ones += int'(b);
      end else begin
        b = 1'($urandom);
      end
      bit_vld[NW'(g)] = v;
      bit_in[NW'(g)]  = b;
      drive_cross(g);
      tick();
      cyc++;
      if (done !== 1'b0 || abort !== 1'b0) early = 1'b1;
    end
    bit_vld = '0;
    tick();
    chk("no_early_done", 32'(early), 32'd0);
    chk("done", 32'(done), 32'd1);
    chk("done_id", 32'(done_id), 32'd1 << g);
    chk("result", 32'(result), (2 * ones >= len) ? 32'd1 : 32'd0);
    chk("gnt_drop", 32'(gnt), 32'd0);
    chk("abort_clr", 32'(abort), 32'd0);
    $display("window req=%0d len=%0d ones=%0d collect_cycles=%0d result=%0b", g, len, ones, cyc, result);
    rr_m = (g + 1) % N;
  endtask

  task automatic run_abort(input int wl, input int nbefore);
    int g;
    win_len = CW'(wl);
    wait_grant(g);
    for (int k = 0; k < nbefore; k++) begin
      bit_vld[NW'(g)] = 1'b1;
      bit_in[NW'(g)]  = 1'($urandom);
      drive_cross(g);
      tick();
    end
    req[NW'(g)]     = 1'b0;
    bit_vld[NW'(g)] = 1'b0;
    drive_cross(g);
    tick();
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_gnt_drop", 32'(gnt), 32'd0);
    chk("abort_busy_low", 32'(busy), 32'd0);
    $display("abort req=%0d after %0d samples", g, nbefore);
    rr_m = (g + 1) % N;
  endtask

`ifdef MAJ_TIMEOUT_EN
  task automatic run_timeout(input int wl);
    int g;
    win_len = CW'(wl);
    wait_grant(g);
    bit_vld[NW'(g)] = 1'b0;
    for (int k = 0; k < TO - 1; k++) begin
      drive_cross(g);
      tick();
    end
    chk("timeout_not_early", 32'(abort), 32'd0);
    drive_cross(g);
    tick();
    chk("timeout_abort", 32'(abort), 32'd1);
    chk("timeout_gnt_drop", 32'(gnt), 32'd0);
    $display("timeout req=%0d after %0d idle cycles", g, TO);
    rr_m = (g + 1) % N;
  endtask
`endif

  initial begin
    int g;
    rst = 1'b0; req = '0; bit_in = '0; bit_vld = '0; win_len = '0;
    repeat (2) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single requester, samples 1,0,1,1,0.
    req = 4'b0001;
    run_window(5, 0, 1'b0, 16'b0_1101);

    // Ties resolve to 1; 1 of 4 does not.
    run_window(4, 0, 1'b0, 16'b1001);
    run_window(4, 0, 1'b0, 16'b0100);

    // Asynchronous reset in the middle of a window.
    win_len = CW'(10);
    wait_grant(g);
    for (int k = 0; k < 2; k++) begin
      bit_vld[NW'(g)] = 1'b1;
      bit_in[NW'(g)]  = 1'b1;
      drive_cross(g);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_done_id", 32'(done_id), 32'd0);
    chk("midrst_abort", 32'(abort), 32'd0);
    $display("reset asserted mid-window on req=%0d", g);
    req = '0; bit_vld = '0;
    rr_m = 0;
    @(negedge clk);
    rst = 1'b1;

    // Fairness: all requesting, one-sample windows.
    req = 4'b1111;
    repeat (5) run_window(1, 0, 1'b1, 16'h0);

    // Gaps on the granted line, crosstalk elsewhere.
    req = 4'b0010;
    run_window(9, 50, 1'b1, 16'h0);
    repeat (8) begin
      req = 4'($urandom_range(1, 15));
      run_window(int'($urandom_range(0, 20)), int'($urandom_range(0, 60)), 1'b1, 16'h0);
    end

    // Zero-length window behaves as one sample.
    req = 4'b0100;
    run_window(0, 0, 1'b0, 16'h0000);
    run_window(0, 0, 1'b0, 16'h0001);

    // Abort on requester 2, then requester 3 gets the next grant.
    req = 4'b0010;
    run_window(3, 0, 1'b1, 16'h0);
    req = 4'b1100;
    run_abort(5, 2);
    run_window(2, 0, 1'b1, 16'h0);

    // Longest window.
    req = 4'b1001;
    run_window(MW, 10, 1'b1, 16'h0);

`ifdef MAJ_TIMEOUT_EN
    req = 4'b0001;
    run_timeout(5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
